freq_meter: RTL and testbench
=============================

// Module: freq_meter
// PURPOSE
//  Measures the frequency of an asynchronous square-wave input against clk_in; the
//  measuring counterpart of the clkfrec divider, used to check divided clocks on-board.
//  Counts synchronized rising edges of sig_in over a fixed gate window of clk_in
//  cycles and reports the result in Hz with a one-cycle valid strobe per window.
// PARAMETERS
//  f_in     100_000_000  frequency of clk_in in Hz
//  gate_hz  10           windows per second; gate_len = f_in/gate_hz cycles (100 ms)
//  out_bits 32           width of freq_hz
// PORTS
//  clk_in    in   1         system clock, single clock domain
//  reset     in   1         synchronous, active-high reset
//  enable    in   1         1 = measure continuously, 0 = idle
//  sig_in    in   1         asynchronous signal under test
//  freq_hz   out  out_bits  last measured frequency in Hz
//  valid     out  1         one-cycle strobe: freq_hz updated this cycle
//  measuring out  1         high while in MEASURE state
// BEHAVIOUR
//  - Reset (sync, active-high, all regs): state IDLE, sync chain 0, counters 0,
//    freq_hz=0, valid=0, measuring=0. Reset mid-window aborts it; no valid issued.
//  - sig_in: 2-FF synchronizer + 1 delay FF; edge = s2 & ~s3 (rising only).
//  - FSM: IDLE -> SETTLE when enable=1; SETTLE lasts 3 cycles (chain fill, edges
//    ignored) -> MEASURE; any state -> IDLE in the cycle after enable=0.
//  - IDLE: gate_cnt and edge_cnt held 0; freq_hz holds last value; valid=0.
//  - MEASURE: gate_cnt counts 0..gate_len-1 and wraps; edge_cnt += edge each cycle.
//  - Window close (gate_cnt==gate_len-1): next cycle freq_hz <= (edge_cnt+edge)*gate_hz,
//    valid=1 for exactly one cycle; edge_cnt <= 0; closing-cycle edge counted in the
//    closing window, never in both. Windows back-to-back, no dead cycles.
//  - Widths: gate_cnt $clog2(gate_len); edge_cnt $clog2(gate_len/2+1), cannot overflow.
//    Product computed at full width; if > 2**out_bits-1, freq_hz saturates to all ones.
//  - Range: sig_in up to f_in/4 exact; resolution gate_hz; static sig_in -> 0.
//  - enable dropped mid-window: window discarded, no valid, freq_hz unchanged.
//  - measuring=1 only in MEASURE; valid never asserted outside MEASURE->close.
// TESTING (f_in=100_000_000, gate_hz=1000 -> gate_len=100_000 unless stated)
//  1 reset 5 cycles, enable=1 at cycle E, sig_in period 100 cycles (1 MHz) -> first
//    valid at cycle E+1+3+100_000 with freq_hz=1_000_000 (+-1000); repeats every 100_000.
//  2 sig_in period 4 cycles (25 MHz) -> freq_hz=25_000_000 (+-1000) each window.
//  3 sig_in held 1 then 0 across windows -> freq_hz=0, valid still every 100_000 cycles.
//  4 reset pulsed 1 cycle at gate_cnt=50_000 -> no valid that window, freq_hz=0,
//    measuring=0; measurement restarts only via IDLE->SETTLE.
//  5 enable=0 at gate_cnt=30_000 after a 1 MHz result -> measuring=0 next cycle, no
//    valid, freq_hz stays 1_000_000.
//  6 out_bits=16, sig_in 1 MHz -> freq_hz=16'hFFFF with valid (saturation).

Source files
------------

// File: rtl/freq_meter.sv
// freq_meter: counts synchronized rising edges of sig_in over a gate window
// of clk_in cycles and reports the result in Hz with a one-cycle valid strobe.
module freq_meter #(
  parameter int f_in     = 100_000_000,
  parameter int gate_hz  = 10,
  parameter int out_bits = 32
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                enable,
  input  logic                sig_in,
  output logic [out_bits-1:0] freq_hz,
  output logic                valid,
  output logic                measuring
);

  localparam int gate_len = f_in / gate_hz;
  localparam int gw = (gate_len > 1) ? $clog2(gate_len) : 1;
  localparam int ew = $clog2(gate_len / 2 + 1);
  localparam int hw = $clog2(gate_hz + 1);
  localparam int pw = ew + hw;
  localparam int mw = (pw > out_bits) ? pw : out_bits;

  localparam logic [gw-1:0] gate_last = gw'(gate_len - 1);
  localparam logic [mw-1:0] out_max = mw'({out_bits{1'b1}});

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE
  } state_t;

  state_t        state;
  logic [1:0]    settle_cnt;
  logic [gw-1:0] gate_cnt;
  logic [ew-1:0] edge_cnt;
  logic          s1, s2, s3;
  logic          rise;
  logic [ew-1:0] total;
  logic [mw-1:0] prod;
  logic [out_bits-1:0] freq_next;

  assign rise  = s2 & ~s3;
  assign total = edge_cnt + ew'(rise);
  assign prod  = mw'(total) * mw'(gate_hz);

  // the closing-cycle edge belongs to the window being closed
  always_comb begin
    freq_next = prod[out_bits-1:0];
    if (prod > out_max) freq_next = '1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      freq_hz    <= '0;
      valid      <= 1'b0;
      measuring  <= 1'b0;
    end else begin
      s1    <= sig_in;
      s2    <= s1;
      s3    <= s2;
      valid <= 1'b0;
      if (!enable) begin
        state      <= IDLE;
        settle_cnt <= '0;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        measuring  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state      <= SETTLE;
            settle_cnt <= '0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
          end
          SETTLE: begin
            if (settle_cnt == 2'd2) begin
              state     <= MEASURE;
              measuring <= 1'b1;
              gate_cnt  <= '0;
              edge_cnt  <= '0;
            end else begin
              settle_cnt <= settle_cnt + 2'd1;
            end
          end
          MEASURE: begin
            if (gate_cnt == gate_last) begin
              gate_cnt <= '0;
              edge_cnt <= '0;
              freq_hz  <= freq_next;
              valid    <= 1'b1;
            end else begin
              gate_cnt <= gate_cnt + gw'(1);
              edge_cnt <= total;
            end
          end
          default: begin
            state     <= IDLE;
            measuring <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: random sig_in patterns scored against a sample-log window
// model; a 32-bit and a saturating 16-bit meter share the stimulus.
module tb_freq_meter;

  localparam int FIN  = 1_000_000;
  localparam int HZ   = 1000;
  localparam int G    = FIN / HZ;
  localparam int MAXC = 32768;

  typedef struct {
    int     v;
    longint f;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        sig_in = 1'b0;
  logic [31:0] freq32;
  logic [15:0] freq16;
  logic        valid32, valid16;
  logic        meas32, meas16;

  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  bit  sig_log [0:MAXC-1];
  exp_t q32[$];
  exp_t q16[$];

  freq_meter #(.f_in(FIN), .gate_hz(HZ), .out_bits(32)) dut32 (
    .clk_in(clk_in), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq_hz(freq32), .valid(valid32), .measuring(meas32)
  );

  freq_meter #(.f_in(FIN), .gate_hz(HZ), .out_bits(16)) dut16 (
    .clk_in(clk_in), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq_hz(freq16), .valid(valid16), .measuring(meas16)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // the value driven here is the one sampled at edge number cyc+1
  always @(negedge clk_in)
    sig_in = (cyc + 1 < MAXC) ? sig_log[cyc+1] : 1'b0;

  function automatic longint sat16(input longint f);
    return (f > 65535) ? 65535 : f;
  endfunction

  // rising transitions of the sample log inside the window closing at edge v
  function automatic longint win_freq(input int v);
    longint n = 0;
    for (int r = v - G - 1; r <= v - 2; r++)
      if (sig_log[r] && !sig_log[r-1]) n++;
    return n * HZ;
  endfunction

  function automatic void push(input int v);
    exp_t x;
    x.v = v;
    x.f = win_freq(v);
    q32.push_back(x);
    x.f = sat16(x.f);
    q16.push_back(x);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    exp_t x;
    if (valid32 === 1'b1) begin
      tests++;
      if (q32.size() == 0) begin
        fails++;
        $display("FAIL valid32 unexpected at cycle %0d freq %0d", cyc, freq32);
      end else begin
        x = q32.pop_front();
        if (x.v != cyc || longint'(freq32) != x.f) begin
          fails++;
          $display("FAIL win32: got cycle %0d freq %0d expected cycle %0d freq %0d",
                   cyc, freq32, x.v, x.f);
        end
      end
    end
  end

  always @(negedge clk_in) begin
    exp_t y;
    if (valid16 === 1'b1) begin
      tests++;
      if (q16.size() == 0) begin
        fails++;
        $display("FAIL valid16 unexpected at cycle %0d freq %0d", cyc, freq16);
      end else begin
        y = q16.pop_front();
        if (y.v != cyc || longint'(freq16) != y.f) begin
          fails++;
          $display("FAIL win16: got cycle %0d freq %0d expected cycle %0d freq %0d",
                   cyc, freq16, y.v, y.f);
        end
      end
    end
  end

  // mode 0 periodic, 1 random runs (>=2 cycles per level), 2 high then low
  task automatic fill(input int start, input int len, input int mode,
                      input int per);
    int ph = $urandom_range(0, per - 1);
    int run = 0;
    bit lvl = 1'b0;
    for (int i = start; i < start + len && i < MAXC; i++) begin
      case (mode)
        0: sig_log[i] = ((i + ph) % per) < (per / 2);
        1: begin
          if (run == 0) begin
            lvl = ~lvl;
            run = $urandom_range(2, 20);
          end
          sig_log[i] = lvl;
          run--;
        end
        default: sig_log[i] = (i - start) < (G + G / 2);
      endcase
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk_in);
  endtask

  // abort: 0 none, 1 reset pulse mid-window, 2 enable drop mid-window
  task automatic run(input int mode, input int per, input int nwin,
                     input int abort);
    int c, e, r;
    longint lastf;
    c = cyc;
    fill(c + 2, nwin * G + 3 * G, mode, per);
    @(negedge clk_in);
    enable = 1'b1;
    e = cyc + 1;
    for (int n = 1; n <= nwin; n++) push(e + 3 + n * G);
    lastf = win_freq(e + 3 + nwin * G);
    wait_cyc(e + 2);
    chk("settle_meas", meas32, 0);
    wait_cyc(e + 3);
    chk("meas_on", meas32, 1);
    if (abort == 0) begin
      wait_cyc(e + 3 + nwin * G + 1);
      enable = 1'b0;
    end else if (abort == 2) begin
      wait_cyc(e + 3 + nwin * G + 299);
      enable = 1'b0;
      @(negedge clk_in);
      chk("drop_meas", meas32, 0);
      chk("drop_valid", valid32, 0);
      wait_cyc(cyc + G + 20);
      chk("drop_hold32", freq32, lastf);
      chk("drop_hold16", freq16, sat16(lastf));
    end else begin
      wait_cyc(e + 3 + nwin * G + 499);
      reset = 1'b1;
      @(negedge clk_in);
      r = cyc;
      reset = 1'b0;
      chk("rst_meas", meas32, 0);
      chk("rst_valid", valid32, 0);
      chk("rst_freq32", freq32, 0);
      chk("rst_freq16", freq16, 0);
      push(r + 4 + G);
      wait_cyc(r + 3);
      chk("restart_settle", meas32, 0);
      wait_cyc(r + 4);
      chk("restart_meas", meas32, 1);
      wait_cyc(r + 5 + G);
      enable = 1'b0;
    end
    repeat (20) @(negedge clk_in);
  endtask

  initial begin
    repeat (5) @(negedge clk_in);
    reset = 1'b0;
    chk("reset_freq32", freq32, 0);
    chk("reset_freq16", freq16, 0);
    chk("reset_valid", valid32, 0);
    chk("reset_meas", meas32, 0);
    run(0, 100, 3, 0);
    run(0, 4, 3, 0);
    run(1, 4, 3, 0);
    run(0, $urandom_range(4, 60), 2, 0);
    run(2, 4, 3, 0);
    run(0, 100, 1, 1);
    run(0, 100, 1, 2);
    chk("idle_meas16", meas16, 0);
    chk("q32_empty", q32.size(), 0);
    chk("q16_empty", q16.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
